// File: rtl/slave_fifo2b_pkg.sv
// Shared definitions for the FX3 Slave FIFO 2-bit stream engines (stream-IN and stream-OUT).
package slave_fifo2b_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned RD_LATENCY_DEF = 2;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FLAGD = 3'd1,
        ST_READ       = 3'd2,
        ST_DRAIN      = 3'd3
    } stream_state_e;

endpackage

// File: rtl/slave_fifo2b_stream_out_if.sv
// FX3 Slave FIFO pins used by the stream-OUT engine; master = FPGA engine, slave = FX3 side.
interface slave_fifo2b_stream_out_if;
    import slave_fifo2b_pkg::*;

    logic  flagc_d;
    logic  flagd_d;
    word_t data_in_stream_out;
    logic  slrd_streamOUT_;
    logic  sloe_streamOUT_;

    modport master (
        input  flagc_d,
        input  flagd_d,
        input  data_in_stream_out,
        output slrd_streamOUT_,
        output sloe_streamOUT_
    );

    modport slave (
        output flagc_d,
        output flagd_d,
        output data_in_stream_out,
        input  slrd_streamOUT_,
        input  sloe_streamOUT_
    );

endinterface

// File: rtl/stream_out_checker.sv
// Incrementing-pattern checker for received stream-OUT words; resyncs to data+1 after every word.
module stream_out_checker
    import slave_fifo2b_pkg::*;
#(
    parameter int unsigned ERR_W = 16
) (
    input  logic             clk_100,
    input  logic             reset,
    input  logic             clear,
    input  logic             valid,
    input  word_t            data,
    output logic [ERR_W-1:0] err_count,
    output logic             err_flag
);

    word_t expected;
    logic  mismatch_c;

    assign mismatch_c = valid && (data != expected);

    // A match and a resync both leave expected at data+1, so one update covers both.
    always_ff @(posedge clk_100) begin
        if (reset || clear) begin
            expected  <= '0;
            err_count <= '0;
            err_flag  <= 1'b0;
        end else if (valid) begin
            expected <= data + DATA_W'(1);
            if (mismatch_c) begin
                err_flag <= 1'b1;
                if (err_count != '1) begin
                    err_count <= err_count + ERR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/slave_fifo2b_stream_out.sv
// Stream-OUT engine: reads the FX3 OUT socket and counts words.
// Optional pattern checker enabled by defining STREAM_OUT_CHECK_EN.
module slave_fifo2b_stream_out
    import slave_fifo2b_pkg::*;
#(
    parameter int unsigned RD_LATENCY = RD_LATENCY_DEF,
    parameter int unsigned ERR_W      = 16
) (
    input  logic                      clk_100,
    input  logic                      reset,
    input  logic                      stream_out_mode_selected,
    slave_fifo2b_stream_out_if.master bus,
    output logic                      rd_valid,
    output logic [DATA_W-1:0]         rx_count,
    output logic [ERR_W-1:0]          err_count,
    output logic                      err_flag
);

    localparam int unsigned CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(RD_LATENCY - 1);

    stream_state_e          state, state_nxt;
    logic [CNT_W-1:0]       drain_cnt, drain_cnt_nxt;
    logic [RD_LATENCY-1:0]  vld_pipe;
    logic                   strobe_c;
    logic                   oe_c;
    logic                   clear_c;

    assign clear_c = ~stream_out_mode_selected;

    always_ff @(posedge clk_100) begin
        if (reset) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // Strobe is gated by the live flags so a flag drop or deselect stops reads in the same cycle.
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        strobe_c      = 1'b0;
        oe_c          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.flagc_d) state_nxt = ST_WAIT_FLAGD;
            end
            ST_WAIT_FLAGD: begin
                if (bus.flagd_d) state_nxt = ST_READ;
            end
            ST_READ: begin
                oe_c     = 1'b1;
                strobe_c = bus.flagd_d;
                if (!bus.flagd_d) begin
                    state_nxt     = ST_DRAIN;
                    drain_cnt_nxt = '0;
                end
            end
            ST_DRAIN: begin
                oe_c = 1'b1;
                if (drain_cnt == DRAIN_LAST) state_nxt = ST_IDLE;
                else drain_cnt_nxt = drain_cnt + CNT_W'(1);
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (!stream_out_mode_selected) begin
            state_nxt = ST_IDLE;
            strobe_c  = 1'b0;
        end
    end

    assign bus.slrd_streamOUT_ = ~strobe_c;
    assign bus.sloe_streamOUT_ = ~oe_c;

    // Valid pipeline mirrors the FX3 read latency; flushed together with the counters on deselect.
    always_ff @(posedge clk_100) begin
        if (reset || clear_c) begin
            vld_pipe <= '0;
            rx_count <= '0;
        end else begin
            vld_pipe <= (vld_pipe << 1) | RD_LATENCY'(strobe_c);
            if (rd_valid) rx_count <= rx_count + DATA_W'(1);
        end
    end

    assign rd_valid = vld_pipe[RD_LATENCY-1];

`ifdef STREAM_OUT_CHECK_EN
    stream_out_checker #(
        .ERR_W (ERR_W)
    ) u_checker (
        .clk_100   (clk_100),
        .reset     (reset),
        .clear     (clear_c),
        .valid     (rd_valid),
        .data      (bus.data_in_stream_out),
        .err_count (err_count),
        .err_flag  (err_flag)
    );
`else
    logic unused_data_c;
    assign unused_data_c = ^bus.data_in_stream_out;
    assign err_count     = '0;
    assign err_flag      = 1'b0;
`endif

endmodule
